// File: rtl/mapper_pkg.sv
// rtl/mapper_pkg.sv - shared sizes, types and RAT lookup helper for the rename stage
package mapper_pkg;

  localparam int ARCH_REGS = 32;
  localparam int ROB_DEPTH = 32;
  localparam int NUM_FU    = 5;
  localparam int XLEN      = 32;
  localparam int AREG_W    = $clog2(ARCH_REGS);
  localparam int TAG_W     = $clog2(ROB_DEPTH);
  localparam int FU_W      = $clog2(NUM_FU);

  typedef enum logic [FU_W-1:0] {
    FU_ALU = 3'd0,
    FU_MUL = 3'd1,
    FU_BR  = 3'd2,
    FU_LSU = 3'd3,
    FU_CSR = 3'd4
  } fu_class_e;

  typedef struct packed {
    logic             busy;
    logic             ready;
    logic [TAG_W-1:0] tag;
  } rat_entry_t;

  typedef struct packed {
    logic             valid;
    logic             rob;
    logic [TAG_W-1:0] tag;
  } src_t;

  typedef struct packed {
    logic [AREG_W-1:0] dr;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic              use_imm;
    logic              eoi;
    logic              exception;
  } uop_t;

  // A busy-but-unready producer still counts as available if it is on the CDB right now.
  function automatic src_t rat_lookup(input rat_entry_t e, input logic is_x0,
                                      input logic cdb_valid, input logic [TAG_W-1:0] cdb_tag);
    src_t s;
    s = '0;
    if (!is_x0 && e.busy) begin
      s.tag   = e.tag;
      s.rob   = e.ready || (cdb_valid && (cdb_tag == e.tag));
      s.valid = s.rob;
    end else begin
      s.valid = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/mapper_rename_if.sv
// rtl/mapper_rename_if.sv - decode/ROB/CDB/retire/dispatch signals of the rename stage
interface mapper_rename_if;
  import mapper_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [AREG_W-1:0] in_dr;
  logic              in_wr_dr;
  logic [AREG_W-1:0] in_sr1;
  logic [AREG_W-1:0] in_sr2;
  logic              in_use_imm;
  logic [XLEN-1:0]   in_imm;
  logic [XLEN-1:0]   in_pc;
  logic [FU_W-1:0]   in_fu_class;
  logic              in_eoi;
  logic              in_exception;
  logic [TAG_W-1:0]  rob_write_ptr;
  logic              rob_full;
  logic              rob_alloc;
  logic [NUM_FU-1:0] fu_full;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic              ret_valid;
  logic [AREG_W-1:0] ret_dr;
  logic [TAG_W-1:0]  ret_tag;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [NUM_FU-1:0] out_fu_target;
  logic [TAG_W-1:0]  out_rob_entry;
  logic              out_src1_valid;
  logic              out_src1_rob;
  logic [TAG_W-1:0]  out_src1_tag;
  logic              out_src2_valid;
  logic              out_src2_rob;
  logic [TAG_W-1:0]  out_src2_tag;
  logic [AREG_W-1:0] out_dr;
  logic [XLEN-1:0]   out_imm;
  logic              out_use_imm;
  logic [XLEN-1:0]   out_pc;
  logic              out_eoi;
  logic              out_exception;

  modport slave (
    input  in_valid, in_dr, in_wr_dr, in_sr1, in_sr2, in_use_imm, in_imm, in_pc,
           in_fu_class, in_eoi, in_exception, rob_write_ptr, rob_full, fu_full,
           cdb_valid, cdb_tag, ret_valid, ret_dr, ret_tag, flush, out_ready,
    output in_ready, rob_alloc, out_valid, out_fu_target, out_rob_entry,
           out_src1_valid, out_src1_rob, out_src1_tag, out_src2_valid, out_src2_rob,
           out_src2_tag, out_dr, out_imm, out_use_imm, out_pc, out_eoi, out_exception
  );

  modport master (
    output in_valid, in_dr, in_wr_dr, in_sr1, in_sr2, in_use_imm, in_imm, in_pc,
           in_fu_class, in_eoi, in_exception, rob_write_ptr, rob_full, fu_full,
           cdb_valid, cdb_tag, ret_valid, ret_dr, ret_tag, flush, out_ready,
    input  in_ready, rob_alloc, out_valid, out_fu_target, out_rob_entry,
           out_src1_valid, out_src1_rob, out_src1_tag, out_src2_valid, out_src2_rob,
           out_src2_tag, out_dr, out_imm, out_use_imm, out_pc, out_eoi, out_exception
  );

endinterface

// File: rtl/mapper_rat.sv
// rtl/mapper_rat.sv - register alias table: two bypassed read ports, rename, retire, wakeup, flush
module mapper_rat
  import mapper_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [AREG_W-1:0] rd1_addr,
  input  logic [AREG_W-1:0] rd2_addr,
  output src_t              rd1,
  output src_t              rd2,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic              ret_valid,
  input  logic [AREG_W-1:0] ret_dr,
  input  logic [TAG_W-1:0]  ret_tag,
  input  logic              wr_en,
  input  logic [AREG_W-1:0] wr_addr,
  input  logic [TAG_W-1:0]  wr_tag
);

  rat_entry_t rat [ARCH_REGS];

  assign rd1 = rat_lookup(rat[rd1_addr], rd1_addr == '0, cdb_valid, cdb_tag);
  assign rd2 = rat_lookup(rat[rd2_addr], rd2_addr == '0, cdb_valid, cdb_tag);

  // Later assignments override earlier ones, so a same-cycle rename beats retire and wakeup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) rat[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat[i].busy  <= 1'b0;
        rat[i].ready <= 1'b0;
      end
    end else begin
      for (int i = 1; i < ARCH_REGS; i++) begin
        if (cdb_valid && rat[i].busy && (rat[i].tag == cdb_tag)) rat[i].ready <= 1'b1;
        if (ret_valid && (ret_dr == AREG_W'(i)) && (rat[i].tag == ret_tag)) begin
          rat[i].busy  <= 1'b0;
          rat[i].ready <= 1'b0;
        end
        if (wr_en && (wr_addr == AREG_W'(i))) begin
          rat[i].busy  <= 1'b1;
          rat[i].ready <= 1'b0;
          rat[i].tag   <= wr_tag;
        end
      end
    end
  end

endmodule

// File: rtl/mapper_rename.sv
// rtl/mapper_rename.sv - rename/dispatch stage: handshake, FU steering, registered output with held wakeup
module mapper_rename
  import mapper_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mapper_rename_if.slave bus
);

  logic [2**FU_W-1:0] fu_full_ext;
  logic               accept;
  logic               rename_en;
  src_t               lk1, lk2, src2_in;
  logic [NUM_FU-1:0]  fu_onehot;

  logic               out_valid_q;
  uop_t               uop_q;
  src_t               src1_q, src2_q;
  logic [NUM_FU-1:0]  fu_q;
  logic [TAG_W-1:0]   rob_q;

  // Class indices beyond the last FU look permanently full.
  always_comb begin
    fu_full_ext             = '1;
    fu_full_ext[NUM_FU-1:0] = bus.fu_full;
  end

  assign bus.in_ready = !bus.flush && !bus.rob_full
                     && (bus.in_exception || !fu_full_ext[bus.in_fu_class])
                     && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.rob_alloc = accept;
  assign rename_en     = accept && bus.in_wr_dr && (bus.in_dr != '0) && !bus.in_exception;
  assign fu_onehot     = bus.in_exception ? '0 : (NUM_FU'(1) << bus.in_fu_class);

  mapper_rat u_rat (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .rd1_addr  (bus.in_sr1),
    .rd2_addr  (bus.in_sr2),
    .rd1       (lk1),
    .rd2       (lk2),
    .cdb_valid (bus.cdb_valid),
    .cdb_tag   (bus.cdb_tag),
    .ret_valid (bus.ret_valid),
    .ret_dr    (bus.ret_dr),
    .ret_tag   (bus.ret_tag),
    .wr_en     (rename_en),
    .wr_addr   (bus.in_dr),
    .wr_tag    (bus.rob_write_ptr)
  );

  always_comb begin
    src2_in = lk2;
    if (bus.in_use_imm) src2_in = '{valid: 1'b1, rob: 1'b0, tag: '0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      uop_q       <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      fu_q        <= '0;
      rob_q       <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      uop_q       <= '{dr: bus.in_dr, imm: bus.in_imm, pc: bus.in_pc, use_imm: bus.in_use_imm,
                       eoi: bus.in_eoi, exception: bus.in_exception};
      src1_q      <= lk1;
      src2_q      <= src2_in;
      fu_q        <= fu_onehot;
      rob_q       <= bus.rob_write_ptr;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end else if (out_valid_q && bus.cdb_valid) begin
      // Stalled uop: catch a broadcast it would otherwise miss while waiting downstream.
      if (!src1_q.valid && (src1_q.tag == bus.cdb_tag)) begin
        src1_q.valid <= 1'b1;
        src1_q.rob   <= 1'b1;
      end
      if (!src2_q.valid && (src2_q.tag == bus.cdb_tag)) begin
        src2_q.valid <= 1'b1;
        src2_q.rob   <= 1'b1;
      end
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_fu_target  = fu_q;
  assign bus.out_rob_entry  = rob_q;
  assign bus.out_src1_valid = src1_q.valid;
  assign bus.out_src1_rob   = src1_q.rob;
  assign bus.out_src1_tag   = src1_q.tag;
  assign bus.out_src2_valid = src2_q.valid;
  assign bus.out_src2_rob   = src2_q.rob;
  assign bus.out_src2_tag   = src2_q.tag;
  assign bus.out_dr         = uop_q.dr;
  assign bus.out_imm        = uop_q.imm;
  assign bus.out_use_imm    = uop_q.use_imm;
  assign bus.out_pc         = uop_q.pc;
  assign bus.out_eoi        = uop_q.eoi;
  assign bus.out_exception  = uop_q.exception;

endmodule

// File: tb/tb_mapper_rename.sv
// tb/tb_mapper_rename.sv - directed self-checking bench for mapper_rename
module tb_mapper_rename;
  import mapper_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   alloc_cnt = 0;

  always #5 clk = ~clk;

  mapper_rename_if bus ();

  mapper_rename dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) begin
    if (rst) alloc_cnt <= 0;
    else if (bus.rob_alloc) alloc_cnt <= alloc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; pulse-type inputs drop right after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.cdb_valid = 1'b0;
    bus.ret_valid = 1'b0;
  endtask

  task automatic uop(input logic [4:0] dr, input logic wr, input logic [4:0] s1,
                     input logic [4:0] s2, input logic [4:0] ptr, input logic [2:0] cls,
                     input logic exc);
    bus.in_valid      = 1'b1;
    bus.in_dr         = dr;
    bus.in_wr_dr      = wr;
    bus.in_sr1        = s1;
    bus.in_sr2        = s2;
    bus.rob_write_ptr = ptr;
    bus.in_fu_class   = cls;
    bus.in_exception  = exc;
    bus.in_use_imm    = 1'b0;
    bus.in_imm        = '0;
    bus.in_pc         = '0;
    bus.in_eoi        = 1'b0;
  endtask

  initial begin
    bus.in_valid = 0; bus.in_dr = 0; bus.in_wr_dr = 0; bus.in_sr1 = 0; bus.in_sr2 = 0;
    bus.in_use_imm = 0; bus.in_imm = 0; bus.in_pc = 0; bus.in_fu_class = 0; bus.in_eoi = 0;
    bus.in_exception = 0; bus.rob_write_ptr = 0; bus.rob_full = 0; bus.fu_full = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.ret_valid = 0; bus.ret_dr = 0; bus.ret_tag = 0;
    bus.flush = 0; bus.out_ready = 1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_fu_target", bus.out_fu_target, 0);
    check("rst_rob_entry", bus.out_rob_entry, 0);
    check("rst_rob_alloc", bus.rob_alloc, 0);
    rst = 1'b0;
    step();

    // 1: rename x5 -> 3, dependent uop sees tag 3 unready
    uop(5, 1, 1, 2, 3, FU_ALU, 0);
    #1 check("t1_alloc_a", bus.rob_alloc, 1);
    step();
    check("t1_valid_a", bus.out_valid, 1);
    check("t1_entry_a", bus.out_rob_entry, 3);
    check("t1_fu_a", bus.out_fu_target, 5'b00001);
    check("t1_s1v_a", bus.out_src1_valid, 1);
    check("t1_s1r_a", bus.out_src1_rob, 0);
    uop(6, 1, 5, 0, 4, FU_MUL, 0);
    #1 check("t1_alloc_b", bus.rob_alloc, 1);
    step();
    check("t1_s1v_b", bus.out_src1_valid, 0);
    check("t1_s1tag_b", bus.out_src1_tag, 3);
    check("t1_s2v_b", bus.out_src2_valid, 1);
    check("t1_fu_b", bus.out_fu_target, 5'b00010);
    check("t1_alloc_cnt", alloc_cnt, 2);

    // 2: CDB bypass in the lookup cycle
    uop(0, 0, 5, 0, 5, FU_ALU, 0);
    bus.cdb_valid = 1; bus.cdb_tag = 3;
    step();
    check("t2_s1v", bus.out_src1_valid, 1);
    check("t2_s1r", bus.out_src1_rob, 1);
    check("t2_s1tag", bus.out_src1_tag, 3);

    // 3: stale retire ignored, matching retire frees, rename beats retire
    uop(5, 1, 0, 0, 7, FU_ALU, 0);
    step();
    bus.ret_valid = 1; bus.ret_dr = 5; bus.ret_tag = 3;
    step();
    uop(0, 0, 5, 0, 8, FU_ALU, 0);
    step();
    check("t3_stale_s1v", bus.out_src1_valid, 0);
    check("t3_stale_tag", bus.out_src1_tag, 7);
    bus.ret_valid = 1; bus.ret_dr = 5; bus.ret_tag = 7;
    step();
    uop(0, 0, 5, 0, 9, FU_ALU, 0);
    step();
    check("t3_arf_s1v", bus.out_src1_valid, 1);
    check("t3_arf_s1r", bus.out_src1_rob, 0);
    uop(5, 1, 0, 0, 10, FU_ALU, 0);
    bus.ret_valid = 1; bus.ret_dr = 5; bus.ret_tag = 7;
    step();
    uop(0, 0, 5, 0, 20, FU_ALU, 0);
    step();
    check("t3_win_s1v", bus.out_src1_valid, 0);
    check("t3_win_tag", bus.out_src1_tag, 10);

    // 4: FU full stall, then held output wakes up from CDB
    bus.fu_full = 5'b00100;
    uop(0, 0, 0, 0, 21, FU_BR, 0);
    #1 check("t4_full_ready", bus.in_ready, 0);
    check("t4_full_alloc", bus.rob_alloc, 0);
    step();
    check("t4_full_ov", bus.out_valid, 0);
    bus.fu_full = 0;
    bus.out_ready = 0;
    uop(0, 0, 0, 6, 11, FU_ALU, 0);
    step();
    check("t4_hold_ov", bus.out_valid, 1);
    check("t4_hold_s2v", bus.out_src2_valid, 0);
    check("t4_hold_tag", bus.out_src2_tag, 4);
    uop(0, 0, 0, 0, 22, FU_ALU, 0);
    #1 check("t4_hold_ready", bus.in_ready, 0);
    bus.in_valid = 0;
    bus.cdb_valid = 1; bus.cdb_tag = 4;
    step();
    check("t4_wake_ov", bus.out_valid, 1);
    check("t4_wake_s2v", bus.out_src2_valid, 1);
    check("t4_wake_s2r", bus.out_src2_rob, 1);
    check("t4_wake_entry", bus.out_rob_entry, 11);
    bus.out_ready = 1;
    step();
    check("t4_drain_ov", bus.out_valid, 0);

    // 5: flush with an output pending and x5/x6/x7 busy
    uop(7, 1, 0, 0, 12, FU_ALU, 0);
    step();
    bus.out_ready = 0;
    bus.flush = 1;
    uop(0, 0, 0, 0, 23, FU_ALU, 0);
    #1 check("t5_flush_ready", bus.in_ready, 0);
    check("t5_flush_alloc", bus.rob_alloc, 0);
    step();
    check("t5_flush_ov", bus.out_valid, 0);
    bus.flush = 0;
    bus.out_ready = 1;
    uop(0, 0, 5, 7, 13, FU_ALU, 0);
    step();
    check("t5_s1v", bus.out_src1_valid, 1);
    check("t5_s1r", bus.out_src1_rob, 0);
    check("t5_s2v", bus.out_src2_valid, 1);
    check("t5_s2r", bus.out_src2_rob, 0);
    uop(0, 0, 6, 0, 24, FU_ALU, 0);
    step();
    check("t5_x6_s1v", bus.out_src1_valid, 1);
    check("t5_x6_s1r", bus.out_src1_rob, 0);

    // 6: exception uop allocates but never renames or targets an FU
    bus.fu_full = 5'b00100;
    uop(9, 1, 0, 0, 14, FU_BR, 1);
    bus.in_eoi = 1;
    #1 check("t6_exc_ready", bus.in_ready, 1);
    check("t6_exc_alloc", bus.rob_alloc, 1);
    step();
    check("t6_exc_fu", bus.out_fu_target, 0);
    check("t6_exc_flag", bus.out_exception, 1);
    check("t6_exc_eoi", bus.out_eoi, 1);
    check("t6_exc_dr", bus.out_dr, 9);
    check("t6_exc_s1v", bus.out_src1_valid, 1);
    check("t6_exc_s2v", bus.out_src2_valid, 1);
    bus.fu_full = 0;
    uop(0, 1, 9, 0, 15, FU_ALU, 0);
    step();
    check("t6_x9_s1v", bus.out_src1_valid, 1);
    check("t6_x9_s1r", bus.out_src1_rob, 0);
    uop(0, 0, 0, 0, 25, FU_LSU, 0);
    step();
    check("t6_x0_s1v", bus.out_src1_valid, 1);
    check("t6_x0_s1r", bus.out_src1_rob, 0);
    check("t6_fu_lsu", bus.out_fu_target, 5'b01000);

    // immediate replaces a busy src2; payload passes through
    uop(8, 1, 0, 0, 16, FU_ALU, 0);
    step();
    uop(0, 0, 8, 8, 17, FU_CSR, 0);
    bus.in_use_imm = 1; bus.in_imm = 32'h1234; bus.in_pc = 32'h80;
    step();
    check("imm_s2v", bus.out_src2_valid, 1);
    check("imm_s2r", bus.out_src2_rob, 0);
    check("imm_s1v", bus.out_src1_valid, 0);
    check("imm_s1tag", bus.out_src1_tag, 16);
    check("imm_val", bus.out_imm, 32'h1234);
    check("imm_pc", bus.out_pc, 32'h80);
    check("imm_flag", bus.out_use_imm, 1);
    check("imm_fu", bus.out_fu_target, 5'b10000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
